// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target. Oversamples scl/sda on clk, detects START/STOP,
//               matches a 7-bit address, receives write bytes on rx_data and
//               serialises read bytes taken from tx_data.
// Macro       : I2C_SLAVE_GENERAL_CALL_EN - also ACK address 7'h00 with R/W=0
//               and accept the following bytes as write data.
// Ports       : clk, rst        - system clock, synchronous active-high reset
//               scl, sda_in     - bus clock / bus data as seen on the wire
//               sda_out         - bus data drive (0 = pull low, 1 = release)
//               tx_data, tx_req - read byte source; tx_data latched on tx_req
//               rx_data, rx_valid - last received byte and its update strobe
//               addressed, rw_bit - transfer status; state - FSM debug view
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       rw_bit,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WRITE    = 3'd3,
    WR_ACK   = 3'd4,
    READ     = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_prev, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  state_t     state_q, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  // Splits each ACK state into its "drive" half and its "finish" half.
  logic       phase, phase_nxt;
  logic       sda_out_nxt, rx_valid_nxt, addressed_nxt, rw_bit_nxt;
  logic [7:0] rx_data_nxt;
  logic [7:0] byte_in;
  logic       gc_hit;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;
  // Byte as it will look once the bit sampled on this rise is shifted in.
  assign byte_in   = {shreg[6:0], sda_s};
  assign state     = state_q;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  assign gc_hit = (byte_in == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      state_q   <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      phase     <= 1'b0;
      sda_out   <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      addressed <= 1'b0;
      rw_bit    <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev  <= scl_s;
      sda_prev  <= sda_s;
      state_q   <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      phase     <= phase_nxt;
      sda_out   <= sda_out_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      addressed <= addressed_nxt;
      rw_bit    <= rw_bit_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    phase_nxt     = phase;
    sda_out_nxt   = sda_out;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    addressed_nxt = addressed;
    rw_bit_nxt    = rw_bit;
    tx_req        = 1'b0;

    // Bus conditions override any bit activity seen in the same cycle.
    if (start_det) begin
      state_nxt     = ADDR;
      bit_cnt_nxt   = 3'd0;
      phase_nxt     = 1'b0;
      sda_out_nxt   = 1'b1;
      addressed_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt     = IDLE;
      phase_nxt     = 1'b0;
      sda_out_nxt   = 1'b1;
      addressed_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_out_nxt = 1'b1;

        ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR || gc_hit) begin
              state_nxt  = ADDR_ACK;
              rw_bit_nxt = byte_in[0];
              phase_nxt  = 1'b0;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end

        ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_out_nxt   = 1'b0;
            addressed_nxt = 1'b1;
            phase_nxt     = 1'b1;
            if (rw_bit) begin
              tx_req    = 1'b1;
              shreg_nxt = tx_data;
            end
          end else begin
            phase_nxt = 1'b0;
            if (rw_bit) begin
              sda_out_nxt = shreg[7];
              shreg_nxt   = {shreg[6:0], 1'b0};
              state_nxt   = READ;
            end else begin
              sda_out_nxt = 1'b1;
              state_nxt   = WRITE;
            end
          end
        end

        WRITE: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
            state_nxt    = WR_ACK;
            phase_nxt    = 1'b0;
          end
        end

        WR_ACK: if (scl_fall) begin
          phase_nxt   = ~phase;
          sda_out_nxt = phase;
          if (phase) state_nxt = WRITE;
        end

        READ: begin
          if (scl_rise) bit_cnt_nxt = bit_cnt + 3'd1;
          // Bit 7 went out on entry, so a fall with the counter back at 0
          // means all eight bits have been clocked out.
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_out_nxt = 1'b1;
              state_nxt   = RD_ACK;
              phase_nxt   = 1'b0;
            end else begin
              sda_out_nxt = shreg[7];
              shreg_nxt   = {shreg[6:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (!phase && scl_rise) begin
            if (!sda_s) begin
              tx_req    = 1'b1;
              shreg_nxt = tx_data;
              phase_nxt = 1'b1;
            end else begin
              state_nxt = IGNORE;
            end
          end else if (phase && scl_fall) begin
            sda_out_nxt = shreg[7];
            shreg_nxt   = {shreg[6:0], 1'b0};
            phase_nxt   = 1'b0;
            state_nxt   = READ;
          end
        end

        IGNORE:  sda_out_nxt = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bus-level bench for i2c_slave. A task-driven I2C master
//               exercises directed and random transfers; expectations come
//               from an address-match rule and the byte tables the bench
//               itself supplies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

  localparam logic [6:0] SLAVE_ADDR = 7'h52;
  localparam int         Q          = 5;   // clk cycles per quarter scl period
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in, sda_out, tx_req, rx_valid, addressed, rw_bit;
  logic [7:0] tx_data, rx_data;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_seq [64];
  int         tx_taken = 0;
  bit         tx_pend  = 1'b0;
  logic [7:0] rx_cap [64];
  int         rx_cnt  = 0;
  int         low_cnt = 0;
  int         viol    = 0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] wdata [8];

  always #5 clk = ~clk;

  // Open-drain bus: whoever pulls low wins.
  assign sda_in  = sda_m & sda_out;
  assign tx_data = tx_seq[tx_taken % 64];

  i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_in), .sda_out(sda_out),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .addressed(addressed), .rw_bit(rw_bit), .state(state)
  );

  // Bus observers. The next table entry is offered one cycle after tx_req,
  // after the slave has latched the current one.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cap[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (tx_req) tx_pend = 1'b1;
    else if (tx_pend) begin
      tx_pend = 1'b0;
      tx_taken++;
    end
    if (!sda_out) low_cnt++;
    if (!rst && scl_m && scl_p && sda_out !== sda_p) viol++;
    scl_p = scl_m;
    sda_p = sda_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    sda_m = b;  tick(Q);
    scl_m = 1'b1; tick(Q);
    seen = sda_in; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(mack, s);
  endtask

  // Reference rule: which address bytes the target answers.
  function automatic bit model_ack(input logic [7:0] ab);
    return (ab[7:1] == SLAVE_ADDR) || (GC_EN && ab == 8'h00);
  endfunction

  task automatic run_write(input logic [7:0] ab, input int n, input bit do_stop);
    int   rx0, low0;
    bit   exp;
    logic ack;
    rx0  = rx_cnt;
    low0 = low_cnt;
    exp  = model_ack(ab);
    bus_start();
    send_byte(ab, ack);
    check("addr_ack", ack, !exp);
    if (exp) check("rw_bit_wr", rw_bit, 0);
    check("addressed", addressed, exp);
    for (int i = 0; i < n; i++) begin
      send_byte(wdata[i], ack);
      check("data_ack", ack, !exp);
    end
    check("rx_count", rx_cnt - rx0, exp ? n : 0);
    if (exp) begin
      for (int i = 0; i < n; i++) check("rx_byte", rx_cap[(rx0 + i) % 64], wdata[i]);
      check("rx_data", rx_data, wdata[n-1]);
    end else begin
      check("sda_never_low", low_cnt - low0, 0);
    end
    if (do_stop) begin
      bus_stop();
      tick(4);
      check("addressed_after_stop", addressed, 0);
      check("idle_after_stop", state, 0);
    end
  endtask

  task automatic run_read(input logic [7:0] ab, input int n, input bit do_stop);
    int         t0;
    bit         exp;
    logic       ack;
    logic [7:0] b;
    exp = model_ack(ab);
    t0  = tx_taken;
    bus_start();
    send_byte(ab, ack);
    check("raddr_ack", ack, !exp);
    if (exp) check("rw_bit_rd", rw_bit, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      check("rd_byte", b, exp ? tx_seq[(t0 + i) % 64] : 8'hFF);
    end
    tick(2);
    check("tx_req_count", tx_taken - t0, exp ? n : 0);
    check("ignore_after_nack", state, 7);
    check("sda_released", sda_out, 1);
    if (do_stop) begin
      bus_stop();
      tick(4);
      check("idle_after_rd_stop", state, 0);
    end
  endtask

  initial begin
    logic       ack, s, r;
    logic [3:0] nib;
    logic [7:0] ab;
    int         n, t;

    for (int i = 0; i < 64; i++) tx_seq[i] = 8'($urandom);

    // Reset values
    tick(3);
    check("rst_sda_out", sda_out, 1);
    check("rst_state", state, 0);
    check("rst_addressed", addressed, 0);
    check("rst_rw_bit", rw_bit, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    rst = 1'b0;
    tick(3);

    // Write to own address
    wdata[0] = 8'h3C;
    run_write(8'hA4, 1, 1'b1);

    // Two-byte read, ACK then NACK
    t = tx_taken;
    tx_seq[t % 64]       = 8'h96;
    tx_seq[(t + 1) % 64] = 8'h0F;
    run_read(8'hA5, 2, 1'b1);

    // Foreign address
    wdata[0] = 8'h55;
    run_write(8'hB0, 1, 1'b1);

    // Write then repeated START into a read
    wdata[0] = 8'h11;
    run_write(8'hA4, 1, 1'b0);
    run_read(8'hA5, 1, 1'b1);
    check("rx_hold", rx_data, 8'h11);

    // General call
    wdata[0] = 8'h22;
    run_write(8'h00, 1, 1'b1);

    // Reset while bit 3 of a 0x00 read byte is on the bus
    t = tx_taken;
    tx_seq[t % 64] = 8'h00;
    bus_start();
    send_byte(8'hA5, ack);
    check("rst_test_addr_ack", ack, 0);
    for (int i = 3; i >= 0; i--) begin
      bus_bit(1'b1, s);
      nib[i] = s;
    end
    check("rst_test_hi_bits", nib, 4'h0);
    tick(2);
    check("bit3_driven_low", sda_out, 0);
    rst = 1'b1;
    tick(1);
    check("midrst_sda_out", sda_out, 1);
    check("midrst_state", state, 0);
    check("midrst_addressed", addressed, 0);
    check("midrst_rw_bit", rw_bit, 0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_outputs", {tx_req, rx_valid}, 2'b00);
    tick(1);
    rst = 1'b0;
    tick(3);
    wdata[0] = 8'h5A;
    run_write(8'hA4, 1, 1'b1);

    // Random transfers
    for (int k = 0; k < 10; k++) begin
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) ab = {SLAVE_ADDR, r};
      else                           ab = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
      if (ab[0]) run_read(ab, n, 1'b1);
      else       run_write(ab, n, 1'b1);
    end

    check("sda_stable_while_scl_high", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
